// File: rtl/quiz_round_controller.sv
// Round sequencer for a four-player buzzer quiz: arming, fouls, round-robin
// buzz arbitration, open/answer countdowns and host judgement.
module quiz_round_controller #(
    parameter int TW            = 8,
    parameter int OPEN_CYCLES   = 16,
    parameter int ANSWER_CYCLES = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    player_en,
    input  logic [3:0]    buzz,
    input  logic          host_start,
    input  logic          host_go,
    input  logic          judge_ok,
    input  logic          judge_bad,
    input  logic          host_clear,
    output logic [2:0]    state,
    output logic [3:0]    winner,
    output logic          winner_valid,
    output logic [3:0]    foul_mask,
    output logic [3:0]    excluded,
    output logic [TW-1:0] timer,
    output logic          stop_timer,
    output logic          round_done,
    output logic          no_winner
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        OPEN   = 3'd2,
        LOCKED = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [TW-1:0] OPEN_LOAD   = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] ANSWER_LOAD = TW'(ANSWER_CYCLES - 1);

    state_t        state_r, state_next_s;
    logic [3:0]    winner_r, winner_next_s;
    logic          winner_valid_r, winner_valid_next_s;
    logic [3:0]    foul_mask_r, foul_mask_next_s;
    logic [3:0]    excluded_r, excluded_next_s;
    logic [TW-1:0] timer_r, timer_next_s;
    logic          no_winner_r, no_winner_next_s;
    logic          stop_timer_r, round_done_r;
    logic [1:0]    rr_ptr_r, rr_ptr_next_s;
    logic [3:0]    buzz_q_r;

    logic [3:0]    eligible_s;
    logic [7:0]    rot_dbl_s;
    logic [3:0]    rot_s;
    logic [1:0]    pick_off_s;
    logic [1:0]    pick_idx_s;
    logic [3:0]    excl_armed_s;
    logic [3:0]    excl_wrong_s;

    // Rising-edge eligibility and round-robin pick starting at rr_ptr
    always_comb begin
        eligible_s = buzz & ~buzz_q_r & player_en & ~excluded_r;
        rot_dbl_s  = {eligible_s, eligible_s} >> rr_ptr_r;
        rot_s      = rot_dbl_s[3:0];
        if (rot_s[0]) begin
            pick_off_s = 2'd0;
        end else if (rot_s[1]) begin
            pick_off_s = 2'd1;
        end else if (rot_s[2]) begin
            pick_off_s = 2'd2;
        end else begin
            pick_off_s = 2'd3;
        end
        pick_idx_s   = rr_ptr_r + pick_off_s;
        excl_armed_s = excluded_r | eligible_s;
        excl_wrong_s = excluded_r | winner_r;
    end

    // Next-state and next-output logic
    always_comb begin
        state_next_s        = state_r;
        winner_next_s       = winner_r;
        winner_valid_next_s = winner_valid_r;
        foul_mask_next_s    = foul_mask_r;
        excluded_next_s     = excluded_r;
        timer_next_s        = timer_r;
        no_winner_next_s    = no_winner_r;
        rr_ptr_next_s       = rr_ptr_r;
        if (host_clear) begin
            state_next_s        = IDLE;
            winner_next_s       = 4'd0;
            winner_valid_next_s = 1'b0;
            foul_mask_next_s    = 4'd0;
            excluded_next_s     = 4'd0;
            timer_next_s        = '0;
            no_winner_next_s    = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (host_start) begin
                        state_next_s = ARMED;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                ARMED: begin
                    foul_mask_next_s = foul_mask_r | eligible_s;
                    excluded_next_s  = excl_armed_s;
                    // A fully fouled-out field ends the round even if go arrives
                    if ((player_en & ~excl_armed_s) == 4'd0) begin
                        state_next_s     = DONE;
                        no_winner_next_s = 1'b1;
                    end else if (host_go) begin
                        state_next_s = OPEN;
                        timer_next_s = OPEN_LOAD;
                    end else begin
                        state_next_s = ARMED;
                    end
                end
                OPEN: begin
                    if (eligible_s != 4'd0) begin
                        state_next_s        = LOCKED;
                        winner_next_s       = 4'b0001 << pick_idx_s;
                        winner_valid_next_s = 1'b1;
                        rr_ptr_next_s       = pick_idx_s + 2'd1;
                        timer_next_s        = ANSWER_LOAD;
                    end else if (timer_r == '0) begin
                        state_next_s     = DONE;
                        no_winner_next_s = 1'b1;
                    end else begin
                        timer_next_s = timer_r - 1'b1;
                    end
                end
                LOCKED: begin
                    if (judge_ok) begin
                        state_next_s     = DONE;
                        no_winner_next_s = 1'b0;
                        timer_next_s     = '0;
                    end else if (judge_bad || (timer_r == '0)) begin
                        excluded_next_s     = excl_wrong_s;
                        winner_next_s       = 4'd0;
                        winner_valid_next_s = 1'b0;
                        if ((player_en & ~excl_wrong_s) != 4'd0) begin
                            state_next_s = OPEN;
                            timer_next_s = OPEN_LOAD;
                        end else begin
                            state_next_s     = DONE;
                            no_winner_next_s = 1'b1;
                            timer_next_s     = '0;
                        end
                    end else begin
                        timer_next_s = timer_r - 1'b1;
                    end
                end
                DONE: begin
                    state_next_s = DONE;
                    timer_next_s = '0;
                end
                default: begin
                    state_next_s = IDLE;
                    timer_next_s = '0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            winner_r       <= 4'd0;
            winner_valid_r <= 1'b0;
            foul_mask_r    <= 4'd0;
            excluded_r     <= 4'd0;
            timer_r        <= '0;
            no_winner_r    <= 1'b0;
            stop_timer_r   <= 1'b0;
            round_done_r   <= 1'b0;
            rr_ptr_r       <= 2'd0;
            buzz_q_r       <= 4'b1111;
        end else begin
            state_r        <= state_next_s;
            winner_r       <= winner_next_s;
            winner_valid_r <= winner_valid_next_s;
            foul_mask_r    <= foul_mask_next_s;
            excluded_r     <= excluded_next_s;
            timer_r        <= timer_next_s;
            no_winner_r    <= no_winner_next_s;
            stop_timer_r   <= (state_next_s == LOCKED) || (state_next_s == DONE);
            round_done_r   <= (state_next_s == DONE);
            rr_ptr_r       <= rr_ptr_next_s;
            buzz_q_r       <= buzz;
        end
    end

    assign state        = state_r;
    assign winner       = winner_r;
    assign winner_valid = winner_valid_r;
    assign foul_mask    = foul_mask_r;
    assign excluded     = excluded_r;
    assign timer        = timer_r;
    assign stop_timer   = stop_timer_r;
    assign round_done   = round_done_r;
    assign no_winner    = no_winner_r;
endmodule

// File: tb/tb_quiz_round_controller.sv
// Bench for quiz_round_controller: fixed vector table, hand-written corner
// sequences and random stimulus checked against a rule-level round model.
module tb_quiz_round_controller;
    localparam int TW = 8;
    localparam int OC = 16;
    localparam int AC = 32;

    logic          clk = 1'b0;
    logic          rst, host_start, host_go, judge_ok, judge_bad, host_clear;
    logic [3:0]    player_en, buzz;
    logic [2:0]    state;
    logic [3:0]    winner, foul_mask, excluded;
    logic          winner_valid, stop_timer, round_done, no_winner;
    logic [TW-1:0] timer;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: integer state code, winner as a player index
    int m_state, m_widx, m_timer, m_rr;
    bit m_nw;
    bit m_excl[4];
    bit m_foul[4];
    bit m_prev[4];

    quiz_round_controller #(.TW(TW), .OPEN_CYCLES(OC), .ANSWER_CYCLES(AC)) dut (
        .clk(clk), .rst(rst), .player_en(player_en), .buzz(buzz),
        .host_start(host_start), .host_go(host_go), .judge_ok(judge_ok),
        .judge_bad(judge_bad), .host_clear(host_clear), .state(state),
        .winner(winner), .winner_valid(winner_valid), .foul_mask(foul_mask),
        .excluded(excluded), .timer(timer), .stop_timer(stop_timer),
        .round_done(round_done), .no_winner(no_winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [3:0] en;
        logic [3:0] b;
        logic       st, go, ok, bad, clr;
        logic [2:0] e_state;
        logic [3:0] e_winner;
        logic [7:0] e_timer;
        logic [3:0] e_excl;
        logic       e_nw;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(input logic r, input logic [3:0] en, input logic [3:0] b,
                                input logic st, input logic go, input logic ok,
                                input logic bad, input logic clr, input logic [2:0] es,
                                input logic [3:0] ew, input logic [7:0] et,
                                input logic [3:0] ex, input logic enw);
        vec_t v;
        v.r = r; v.en = en; v.b = b; v.st = st; v.go = go; v.ok = ok; v.bad = bad;
        v.clr = clr; v.e_state = es; v.e_winner = ew; v.e_timer = et; v.e_excl = ex;
        v.e_nw = enw;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit any_left(input logic [3:0] en);
        bit r = 1'b0;
        for (int i = 0; i < 4; i++) if (en[i] && !m_excl[i]) r = 1'b1;
        return r;
    endfunction

    // Applies the round rules for one clock using the currently driven inputs
    task automatic model_step();
        bit elig[4];
        bit found;
        for (int i = 0; i < 4; i++)
            elig[i] = buzz[i] && !m_prev[i] && player_en[i] && !m_excl[i];
        if (rst) begin
            m_state = 0; m_widx = -1; m_timer = 0; m_rr = 0; m_nw = 0;
            for (int i = 0; i < 4; i++) begin m_excl[i] = 0; m_foul[i] = 0; end
        end else if (host_clear) begin
            m_state = 0; m_widx = -1; m_timer = 0; m_nw = 0;
            for (int i = 0; i < 4; i++) begin m_excl[i] = 0; m_foul[i] = 0; end
        end else begin
            case (m_state)
                0: if (host_start) m_state = 1;
                1: begin
                    for (int i = 0; i < 4; i++)
                        if (elig[i]) begin m_foul[i] = 1; m_excl[i] = 1; end
                    if (!any_left(player_en)) begin m_state = 4; m_nw = 1; end
                    else if (host_go) begin m_state = 2; m_timer = OC - 1; end
                end
                2: begin
                    found = 0;
                    for (int k = 0; k < 4; k++)
                        if (!found && elig[(m_rr + k) % 4]) begin
                            found = 1; m_widx = (m_rr + k) % 4;
                        end
                    if (found) begin
                        m_rr = (m_widx + 1) % 4; m_state = 3; m_timer = AC - 1;
                    end else if (m_timer == 0) begin
                        m_state = 4; m_nw = 1;
                    end else m_timer--;
                end
                3: begin
                    if (judge_ok) begin m_state = 4; m_nw = 0; m_timer = 0; end
                    else if (judge_bad || m_timer == 0) begin
                        m_excl[m_widx] = 1; m_widx = -1;
                        if (any_left(player_en)) begin m_state = 2; m_timer = OC - 1; end
                        else begin m_state = 4; m_nw = 1; m_timer = 0; end
                    end else m_timer--;
                end
                default: m_timer = 0;
            endcase
        end
        for (int i = 0; i < 4; i++) m_prev[i] = rst ? 1'b1 : buzz[i];
    endtask

    task automatic check_model();
        logic [3:0] ew, ex, ef;
        ew = (m_widx >= 0) ? (4'b0001 << m_widx) : 4'd0;
        for (int i = 0; i < 4; i++) begin ex[i] = m_excl[i]; ef[i] = m_foul[i]; end
        chk("m_state", 32'(state), 32'(m_state));
        chk("m_winner", 32'(winner), 32'(ew));
        chk("m_winner_valid", 32'(winner_valid), 32'(m_widx >= 0));
        chk("m_foul_mask", 32'(foul_mask), 32'(ef));
        chk("m_excluded", 32'(excluded), 32'(ex));
        chk("m_timer", 32'(timer), 32'(m_timer));
        chk("m_stop_timer", 32'(stop_timer), 32'(m_state == 3 || m_state == 4));
        chk("m_round_done", 32'(round_done), 32'(m_state == 4));
        chk("m_no_winner", 32'(no_winner), 32'(m_nw));
    endtask

    task automatic apply(input logic r, input logic [3:0] en, input logic [3:0] b,
                         input logic st, input logic go, input logic ok,
                         input logic bad, input logic clr);
        rst = r; player_en = en; buzz = b; host_start = st; host_go = go;
        judge_ok = ok; judge_bad = bad; host_clear = clr;
        model_step();
        @(posedge clk); #1;
        check_model();
    endtask

    task automatic idle(input logic [3:0] en, input logic [3:0] b, input int n);
        for (int i = 0; i < n; i++) apply(0, en, b, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // r en b st go ok bad clr | state winner timer excl nw
        tbl[0]  = mk(1, 4'hF, 4'h0, 0, 0, 0, 0, 0, 3'd0, 4'h0, 8'd0,  4'h0, 0);
        tbl[1]  = mk(0, 4'hF, 4'h0, 1, 0, 0, 0, 0, 3'd1, 4'h0, 8'd0,  4'h0, 0);
        tbl[2]  = mk(0, 4'hF, 4'h0, 0, 1, 0, 0, 0, 3'd2, 4'h0, 8'd15, 4'h0, 0);
        tbl[3]  = mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 0, 3'd2, 4'h0, 8'd14, 4'h0, 0);
        tbl[4]  = mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 0, 3'd2, 4'h0, 8'd13, 4'h0, 0);
        tbl[5]  = mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 0, 3'd2, 4'h0, 8'd12, 4'h0, 0);
        tbl[6]  = mk(0, 4'hF, 4'h4, 0, 0, 0, 0, 0, 3'd3, 4'h4, 8'd31, 4'h0, 0);
        tbl[7]  = mk(0, 4'hF, 4'h4, 0, 0, 0, 0, 0, 3'd3, 4'h4, 8'd30, 4'h0, 0);
        tbl[8]  = mk(0, 4'hF, 4'h0, 0, 0, 1, 0, 0, 3'd4, 4'h4, 8'd0,  4'h0, 0);
        tbl[9]  = mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 0, 3'd4, 4'h4, 8'd0,  4'h0, 0);
        tbl[10] = mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 1, 3'd0, 4'h0, 8'd0,  4'h0, 0);
        tbl[11] = mk(1, 4'hF, 4'h0, 0, 0, 0, 0, 0, 3'd0, 4'h0, 8'd0,  4'h0, 0);
        tbl[12] = mk(0, 4'hF, 4'h0, 1, 0, 0, 0, 0, 3'd1, 4'h0, 8'd0,  4'h0, 0);
        tbl[13] = mk(0, 4'hF, 4'h0, 0, 1, 0, 0, 0, 3'd2, 4'h0, 8'd15, 4'h0, 0);
        tbl[14] = mk(0, 4'hF, 4'h9, 0, 0, 0, 0, 0, 3'd3, 4'h1, 8'd31, 4'h0, 0);
        tbl[15] = mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 1, 3'd0, 4'h0, 8'd0,  4'h0, 0);
        tbl[16] = mk(0, 4'hF, 4'h0, 1, 0, 0, 0, 0, 3'd1, 4'h0, 8'd0,  4'h0, 0);
        tbl[17] = mk(0, 4'hF, 4'h0, 0, 1, 0, 0, 0, 3'd2, 4'h0, 8'd15, 4'h0, 0);
        tbl[18] = mk(0, 4'hF, 4'h9, 0, 0, 0, 0, 0, 3'd3, 4'h8, 8'd31, 4'h0, 0);
        tbl[19] = mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 1, 3'd0, 4'h0, 8'd0,  4'h0, 0);
        tbl[20] = mk(0, 4'hF, 4'h0, 1, 0, 0, 0, 0, 3'd1, 4'h0, 8'd0,  4'h0, 0);
        tbl[21] = mk(0, 4'hF, 4'h2, 0, 0, 0, 0, 0, 3'd1, 4'h0, 8'd0,  4'h2, 0);
        tbl[22] = mk(0, 4'hF, 4'h0, 0, 1, 0, 0, 0, 3'd2, 4'h0, 8'd15, 4'h2, 0);
        tbl[23] = mk(0, 4'hF, 4'h2, 0, 0, 0, 0, 0, 3'd2, 4'h0, 8'd14, 4'h2, 0);
        tbl[24] = mk(0, 4'hF, 4'h3, 0, 0, 0, 0, 0, 3'd3, 4'h1, 8'd31, 4'h2, 0);
        tbl[25] = mk(0, 4'hF, 4'h0, 0, 0, 0, 0, 1, 3'd0, 4'h0, 8'd0,  4'h0, 0);

        for (int i = 0; i < 26; i++) begin
            apply(tbl[i].r, tbl[i].en, tbl[i].b, tbl[i].st, tbl[i].go,
                  tbl[i].ok, tbl[i].bad, tbl[i].clr);
            chk("t_state", 32'(state), 32'(tbl[i].e_state));
            chk("t_winner", 32'(winner), 32'(tbl[i].e_winner));
            chk("t_timer", 32'(timer), 32'(tbl[i].e_timer));
            chk("t_excluded", 32'(excluded), 32'(tbl[i].e_excl));
            chk("t_no_winner", 32'(no_winner), 32'(tbl[i].e_nw));
        end

        // Open window expires with no buzz
        apply(1, 4'hF, 4'h0, 0, 0, 0, 0, 0);
        apply(0, 4'hF, 4'h0, 1, 0, 0, 0, 0);
        apply(0, 4'hF, 4'h0, 0, 1, 0, 0, 0);
        idle(4'hF, 4'h0, 15);
        chk("to_last_state", 32'(state), 32'd2);
        chk("to_last_timer", 32'(timer), 32'd0);
        idle(4'hF, 4'h0, 1);
        chk("to_state", 32'(state), 32'd4);
        chk("to_no_winner", 32'(no_winner), 32'd1);
        chk("to_valid", 32'(winner_valid), 32'd0);

        // Buzz on the timer==0 cycle still wins
        apply(1, 4'hF, 4'h0, 0, 0, 0, 0, 0);
        apply(0, 4'hF, 4'h0, 1, 0, 0, 0, 0);
        apply(0, 4'hF, 4'h0, 0, 1, 0, 0, 0);
        idle(4'hF, 4'h0, 15);
        apply(0, 4'hF, 4'h2, 0, 0, 0, 0, 0);
        chk("last_buzz_state", 32'(state), 32'd3);
        chk("last_buzz_winner", 32'(winner), 32'h2);
        apply(0, 4'hF, 4'h0, 0, 0, 0, 0, 1);

        // Two-player game: wrong answer, then answer timeout
        apply(1, 4'h3, 4'h0, 0, 0, 0, 0, 0);
        apply(0, 4'h3, 4'h0, 1, 0, 0, 0, 0);
        apply(0, 4'h3, 4'h0, 0, 1, 0, 0, 0);
        apply(0, 4'h3, 4'h1, 0, 0, 0, 0, 0);
        chk("p2_winner0", 32'(winner), 32'h1);
        apply(0, 4'h3, 4'h0, 0, 0, 0, 1, 0);
        chk("bad_state", 32'(state), 32'd2);
        chk("bad_timer", 32'(timer), 32'd15);
        chk("bad_excluded", 32'(excluded), 32'h1);
        chk("bad_winner", 32'(winner), 32'h0);
        apply(0, 4'h3, 4'hC, 0, 0, 0, 0, 0);
        chk("disabled_ignored", 32'(state), 32'd2);
        apply(0, 4'h3, 4'hE, 0, 0, 0, 0, 0);
        chk("p2_winner1", 32'(winner), 32'h2);
        idle(4'h3, 4'h0, 31);
        chk("ans_last_state", 32'(state), 32'd3);
        idle(4'h3, 4'h0, 1);
        chk("ans_to_state", 32'(state), 32'd4);
        chk("ans_to_no_winner", 32'(no_winner), 32'd1);
        chk("ans_to_excluded", 32'(excluded), 32'h3);

        // Button held through reset, then clear in LOCKED keeps rr_ptr
        apply(1, 4'hF, 4'h4, 0, 0, 0, 0, 0);
        apply(0, 4'hF, 4'h4, 1, 0, 0, 0, 0);
        apply(0, 4'hF, 4'h4, 0, 1, 0, 0, 0);
        idle(4'hF, 4'h4, 3);
        chk("held_state", 32'(state), 32'd2);
        chk("held_valid", 32'(winner_valid), 32'd0);
        apply(0, 4'hF, 4'h0, 0, 0, 0, 0, 0);
        apply(0, 4'hF, 4'h4, 0, 0, 0, 0, 0);
        chk("repress_winner", 32'(winner), 32'h4);
        apply(0, 4'hF, 4'h4, 0, 0, 0, 0, 1);
        chk("clr_state", 32'(state), 32'd0);
        chk("clr_winner", 32'(winner), 32'h0);
        chk("clr_timer", 32'(timer), 32'd0);
        chk("clr_stop", 32'(stop_timer), 32'd0);
        apply(0, 4'hF, 4'h0, 1, 0, 0, 0, 0);
        apply(0, 4'hF, 4'h0, 0, 1, 0, 0, 0);
        apply(0, 4'hF, 4'hF, 0, 0, 0, 0, 0);
        chk("rr_kept_winner", 32'(winner), 32'h8);

        // Random stimulus against the model
        begin
            logic [3:0] en_v, b_v;
            en_v = 4'hF;
            b_v  = 4'h0;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 49) == 0) en_v = 4'($urandom_range(0, 15));
                for (int i = 0; i < 4; i++)
                    if ($urandom_range(0, 3) == 0) b_v[i] = ~b_v[i];
                apply($urandom_range(0, 99) == 0, en_v, b_v,
                      $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                      $urandom_range(0, 39) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
